// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL   = 4'hF;
  localparam logic [3:0] BE_NONE   = 4'h0;
  localparam int         DEPTH_DEF = 64;
  localparam int         IDX_W_DEF = $clog2(DEPTH_DEF);

  // Round-robin pick between two requesters: a lone requester wins,
  // on contention the one that was not served last wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    case (valid)
      2'b10:   return 1'b1;
      2'b11:   return ~last;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_be_merge.sv
// Byte-lane merge: bytes with an enable take new data, the rest keep the old word.
module dmem_be_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] hold,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic [DATA_W-1:0] merged
);

  // Per-lane select between the old word and the store data.
  always_comb begin
    merged = hold;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port word memory with
// read-modify-write partial stores and out-of-range detection.
//
// state | meaning
// IDLE  | accept one request (round-robin), decide the access path
// RD    | read the addressed word into hold
// WR    | single-cycle memory write of the merged word
// RESP  | one-cycle response pulse to the owner
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rq_valid,
  input  logic [1:0]        rq_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic [3:0]        rq0_be,
  input  logic [3:0]        rq1_be,
  output logic [1:0]        rq_ready,
  output logic [1:0]        rs_valid,
  output logic              rs_err,
  output logic [DATA_W-1:0] rs_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              last_grant;
  logic              id_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic [3:0]        be_q;

  logic              grant;
  logic              hs;
  logic              g_we;
  logic [ADDR_W-3:0] g_word;
  logic [DATA_W-1:0] g_wdata;
  logic [3:0]        g_be;
  logic              g_oor;
  logic [DATA_W-1:0] m_hold;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_be;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_lsb;

  // Byte offset bits are ignored: the memory is word addressed.
  assign unused_addr_lsb = ^{rq0_addr[1:0], rq1_addr[1:0]};

  // Grant selection, ready, and the request fields of the granted requester.
  always_comb begin
    grant    = rr_pick(rq_valid, last_grant);
    hs       = (state == IDLE) && (rq_valid != 2'b00);
    rq_ready = 2'b00;
    if (hs) rq_ready[grant] = 1'b1;
    g_we    = rq_we[grant];
    g_word  = grant ? rq1_addr[ADDR_W-1:2] : rq0_addr[ADDR_W-1:2];
    g_wdata = grant ? rq1_wdata : rq0_wdata;
    g_be    = grant ? rq1_be : rq0_be;
    g_oor   = g_word >= (ADDR_W-2)'(DEPTH);
  end

  // Merge inputs: a full store from IDLE merges against zero, a partial
  // store merges against the word being read in RD.
  always_comb begin
    m_hold  = (state == RD) ? mem_rdata : '0;
    m_wdata = (state == IDLE) ? g_wdata : wdata_q;
    m_be    = (state == IDLE) ? g_be : be_q;
  end

  dmem_be_merge #(.DATA_W(DATA_W)) u_merge (
    .hold   (m_hold),
    .wdata  (m_wdata),
    .be     (m_be),
    .merged (merged)
  );

  // Sequencer with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hold_q     <= '0;
      be_q       <= '0;
      rs_valid   <= 2'b00;
      rs_err     <= 1'b0;
      rs_rdata   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we   <= 1'b0;
      rs_valid <= 2'b00;
      rs_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            id_q    <= grant;
            we_q    <= g_we;
            wdata_q <= g_wdata;
            be_q    <= g_be;
            if (g_oor) begin
              state    <= RESP;
              rs_valid <= grant ? 2'b10 : 2'b01;
              rs_err   <= 1'b1;
              rs_rdata <= '0;
            end else if (g_we && (g_be == BE_FULL)) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_addr  <= {g_word, 2'b00};
              mem_wdata <= merged;
              hold_q    <= '0;
            end else begin
              state    <= RD;
              mem_addr <= {g_word, 2'b00};
            end
          end
        end
        RD: begin
          hold_q <= mem_rdata;
          if (we_q && (be_q != BE_NONE)) begin
            state     <= WR;
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state    <= RESP;
            rs_valid <= id_q ? 2'b10 : 2'b01;
            rs_rdata <= mem_rdata;
          end
        end
        WR: begin
          state    <= RESP;
          rs_valid <= id_q ? 2'b10 : 2'b01;
          rs_rdata <= (be_q == BE_FULL) ? '0 : hold_q;
        end
        default: begin
          last_grant <= id_q;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
